pipe_ctrl: RTL

Central stall/flush and PC-update controller for the l2 in-order core. It sequences the four stage registers (ifu2idu, idu2exu, exu2lsu, lsu2wbu) and the IFU PC register. It resolves load-use hazards, multi-cycle data-memory waits, fetch waits and EXU branch/jump redirects, including redirects that arrive while a fetch is in flight. It also keeps stall and redirect event counters for performance debug.

---
 rtl/pipe_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush and PC-update controller for the l2 in-order core pipeline.
// Resolves load-use, data-memory waits, fetch waits and EXU redirects, with saturating event counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ADDR_ZERO
`define ADDR_ZERO {`ADDR_WIDTH{1'b0}}
`endif

module pipe_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_rst_n,
    input  logic                   i_ifu_busy,
    input  logic                   i_idu_load_use,
    input  logic                   i_exu_jump_valid,
    input  logic [`ADDR_WIDTH-1:0] i_exu_jump_pc,
    input  logic                   i_lsu_busy,
    output logic [3:0]             o_ctrl_stall,
    output logic [3:0]             o_ctrl_flush,
    output logic                   o_ctrl_pc_we,
    output logic                   o_ctrl_pc_sel,
    output logic [`ADDR_WIDTH-1:0] o_ctrl_pc,
    output logic [1:0]             o_ctrl_state,
    output logic [CNT_WIDTH-1:0]   o_ctrl_stall_cnt,
    output logic [CNT_WIDTH-1:0]   o_ctrl_redir_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_MEMW  = 2'd2,
        ST_REDIR = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [`ADDR_WIDTH-1:0]   redir_pc_q, redir_pc_d;
    logic [CNT_WIDTH-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]     redir_cnt_q, redir_cnt_d;
    logic [3:0]               stall_s, flush_s;
    logic                     pc_we_s, pc_sel_s, redir_evt_s;
    logic [`ADDR_WIDTH-1:0]   pc_s;

    // Next-state and zero-latency pipeline controls; reset low presents BOOT outputs.
    always_comb begin
        state_d     = state_q;
        redir_pc_d  = redir_pc_q;
        stall_s     = 4'b0000;
        flush_s     = 4'b0000;
        pc_we_s     = 1'b0;
        pc_sel_s    = 1'b0;
        pc_s        = redir_pc_q;
        redir_evt_s = 1'b0;
        if (!i_sys_rst_n) begin
            flush_s = 4'b1111;
            state_d = ST_BOOT;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    flush_s = 4'b1111;
                    state_d = ST_RUN;
                end
                // MEMW with lsu still busy yields exactly RUN rule 1, so both share one table.
                ST_RUN, ST_MEMW: begin
                    if (i_lsu_busy) begin
                        stall_s = 4'b0111;
                        flush_s = 4'b1000;
                        state_d = ST_MEMW;
                    end else if (i_exu_jump_valid) begin
                        flush_s     = 4'b0011;
                        redir_pc_d  = i_exu_jump_pc;
                        redir_evt_s = 1'b1;
                        if (!i_ifu_busy) begin
                            pc_we_s  = 1'b1;
                            pc_sel_s = 1'b1;
                            pc_s     = i_exu_jump_pc;
                            state_d  = ST_RUN;
                        end else begin
                            state_d = ST_REDIR;
                        end
                    end else if (i_idu_load_use) begin
                        stall_s = 4'b0001;
                        flush_s = 4'b0010;
                        state_d = ST_RUN;
                    end else if (i_ifu_busy) begin
                        flush_s = 4'b0001;
                        state_d = ST_RUN;
                    end else begin
                        pc_we_s = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_REDIR: begin
                    if (i_lsu_busy) begin
                        stall_s = 4'b0111;
                        flush_s = 4'b1000;
                    end else if (i_ifu_busy) begin
                        flush_s = 4'b0001;
                    end else begin
                        flush_s  = 4'b0001;
                        pc_we_s  = 1'b1;
                        pc_sel_s = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
                default: begin
                    flush_s = 4'b1111;
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    // Saturating event counters.
    always_comb begin
        if ((state_q != ST_BOOT) && (stall_s != 4'b0000) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (redir_evt_s && (redir_cnt_q != CNT_MAX)) begin
            redir_cnt_d = redir_cnt_q + CNT_ONE;
        end else begin
            redir_cnt_d = redir_cnt_q;
        end
    end

    // State, redirect target and counter registers.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            state_q     <= ST_BOOT;
            redir_pc_q  <= `ADDR_ZERO;
            stall_cnt_q <= {CNT_WIDTH{1'b0}};
            redir_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            redir_pc_q  <= redir_pc_d;
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign o_ctrl_stall     = stall_s;
    assign o_ctrl_flush     = flush_s;
    assign o_ctrl_pc_we     = pc_we_s;
    assign o_ctrl_pc_sel    = pc_sel_s;
    assign o_ctrl_pc        = pc_s;
    assign o_ctrl_state     = i_sys_rst_n ? state_q : ST_BOOT;
    assign o_ctrl_stall_cnt = stall_cnt_q;
    assign o_ctrl_redir_cnt = redir_cnt_q;

endmodule
